// File: rtl/debounce_multi_pkg.sv
// Shared definitions for the multi-channel debouncer: hold/repeat FSM
// encodings, 100 MHz time constants and a small sizing helper.
package debounce_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } hold_state_t;

    // Time constants expressed in 100 MHz clock cycles
    localparam int unsigned DB_10MS    = 1_000_000;
    localparam int unsigned HOLD_500MS = 50_000_000;
    localparam int unsigned REP_100MS  = 10_000_000;

    // Larger of two cycle counts, used to size the shared hold/repeat timer
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_multi_channel.sv
// One debouncer channel: 2-flop synchroniser, stable-time filter producing
// the accepted level plus press/release pulses, and a hold/repeat FSM.
module debounce_multi_channel
    import debounce_multi_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DB_10MS,
    parameter int unsigned HOLD_CYCLES   = HOLD_500MS,
    parameter int unsigned REPEAT_CYCLES = REP_100MS,
    parameter int unsigned REPEAT_EN     = 1
) (
    input  logic clock_100mhz,
    input  logic resetn,
    input  logic noisesig,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int TMR_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic             REP_ON    = (REPEAT_EN != 0);

    logic             s1_reg, s2_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             hold_reg, hold_next;
    logic             repeat_reg, repeat_next;
    hold_state_t      state_reg, state_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;

    // Two-flop synchroniser; only s2_reg is used downstream
    always_ff @(posedge clock_100mhz) begin
        if (!resetn) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= noisesig;
            s2_reg <= s1_reg;
        end
    end

    // Stable-time filter: any agreement with the accepted level restarts the count
    always_comb begin
        cnt_next     = '0;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (s2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next   = s2_reg;
                press_next   = s2_reg;
                release_next = ~s2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // Hold/repeat next state; an accepted release overrides everything
    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (press_next) begin
                    state_next = ST_PRESSED;
                    tmr_next   = '0;
                end
            end
            ST_PRESSED: begin
                if (tmr_reg == HOLD_LAST) begin
                    state_next = ST_HELD;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            ST_HELD: begin
                if (tmr_reg == REP_LAST) begin
                    tmr_next = '0;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                tmr_next   = '0;
            end
        endcase
        if (release_next) begin
            state_next = ST_IDLE;
            tmr_next   = '0;
        end
    end

    // Hold/repeat pulse decode; suppressed when a release lands on the terminal count
    always_comb begin
        hold_next   = 1'b0;
        repeat_next = 1'b0;
        if (!release_next) begin
            if (state_reg == ST_PRESSED && tmr_reg == HOLD_LAST) begin
                hold_next   = 1'b1;
                repeat_next = REP_ON;
            end else if (state_reg == ST_HELD && tmr_reg == REP_LAST) begin
                repeat_next = REP_ON;
            end
        end
    end

    // State, counters and registered one-cycle pulse outputs
    always_ff @(posedge clock_100mhz) begin
        if (!resetn) begin
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            hold_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
            state_reg   <= ST_IDLE;
            tmr_reg     <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            hold_reg    <= hold_next;
            repeat_reg  <= repeat_next;
            state_reg   <= state_next;
            tmr_reg     <= tmr_next;
        end
    end

    assign level         = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign hold_pulse    = hold_reg;
    assign repeat_pulse  = repeat_reg;

endmodule

// File: rtl/debounce_multi.sv
// N independent debouncer/event channels sharing one clock and reset.
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int          N_CH          = 5,
    parameter int unsigned STABLE_CYCLES = DB_10MS,
    parameter int unsigned HOLD_CYCLES   = HOLD_500MS,
    parameter int unsigned REPEAT_CYCLES = REP_100MS,
    parameter int unsigned REPEAT_EN     = 1
) (
    input  logic            clock_100mhz,
    input  logic            resetn,
    input  logic [N_CH-1:0] noisesig,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_multi_channel #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .HOLD_CYCLES  (HOLD_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES),
                .REPEAT_EN    (REPEAT_EN)
            ) u_ch (
                .clock_100mhz (clock_100mhz),
                .resetn       (resetn),
                .noisesig     (noisesig[gi]),
                .level        (level[gi]),
                .press_pulse  (press_pulse[gi]),
                .release_pulse(release_pulse[gi]),
                .hold_pulse   (hold_pulse[gi]),
                .repeat_pulse (repeat_pulse[gi])
            );
        end
    endgenerate

endmodule
